// File: rtl/inc_dec_pkg.sv
// Shared constants and the wide add/subtract helper used by the increment/decrement core.
// The helper works at a fixed wide width; callers slice out {carry, result} for their WIDTH.
package inc_dec_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Widest counter the helper supports is CALC_W-1 bits.
    localparam int CALC_W = 64;

    // With a and step zero-extended from WIDTH bits, bit WIDTH of the return value is
    // the carry (up) or borrow (down); bits [WIDTH-1:0] are the wrapped result.
    function automatic logic [CALC_W:0] inc_dec_calc(
        input logic [CALC_W-1:0] a,
        input logic [CALC_W-1:0] step,
        input logic              inc
    );
        logic [CALC_W:0] ext_a;
        logic [CALC_W:0] ext_step;
        ext_a    = {1'b0, a};
        ext_step = {1'b0, step};
        return inc ? (ext_a + ext_step) : (ext_a - ext_step);
    endfunction

endpackage

// File: rtl/inc_dec_step.sv
// Combinational increment/decrement by a programmable step, with wrap or saturate on
// overflow/underflow; generalises the fixed 8-bit +/-1 unit.
module inc_dec_step
    import inc_dec_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int STEP_WIDTH = 4,
    parameter int MODE       = MODE_WRAP
) (
    input  logic [WIDTH-1:0]      a,
    input  logic                  inc,
    input  logic [STEP_WIDTH-1:0] step,
    output logic [WIDTH-1:0]      result,
    output logic                  cout
);

    logic [CALC_W-WIDTH-1:0] unused_hi;
    logic                    carry;
    logic [WIDTH-1:0]        raw;

    assign {unused_hi, carry, raw} = inc_dec_calc(CALC_W'(a), CALC_W'(step), inc);

    // A carry in saturate mode pins the result to the bound in the direction of travel,
    // which also covers stepping further from a value already at that bound.
    always_comb begin
        result = raw;
        cout   = carry;
        if (MODE == MODE_SAT && carry) begin
            result = inc ? '1 : '0;
        end
    end

endmodule

// File: rtl/inc_dec_counter.sv
// Registered up/down counter: load > enable > hold, with a one-cycle carry/borrow pulse
// and zero/at_max decodes of the registered value.
module inc_dec_counter
    import inc_dec_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               STEP_WIDTH  = 4,
    parameter int               MODE        = MODE_WRAP,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  inc,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    output logic [WIDTH-1:0]      q,
    output logic                  cout,
    output logic                  zero,
    output logic                  at_max
);

    logic [WIDTH-1:0] step_result;
    logic             step_cout;
    logic [WIDTH-1:0] q_next;
    logic             cout_next;

    inc_dec_step #(
        .WIDTH      (WIDTH),
        .STEP_WIDTH (STEP_WIDTH),
        .MODE       (MODE)
    ) u_step (
        .a      (q),
        .inc    (inc),
        .step   (step),
        .result (step_result),
        .cout   (step_cout)
    );

    always_comb begin
        q_next    = q;
        cout_next = 1'b0;
        if (load) begin
            q_next = load_value;
        end else if (en) begin
            q_next    = step_result;
            cout_next = step_cout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= RESET_VALUE;
            cout <= 1'b0;
        end else begin
            q    <= q_next;
            cout <= cout_next;
        end
    end

    assign zero   = (q == '0);
    assign at_max = (q == '1);

endmodule

// File: tb/tb_inc_dec_counter.sv
// Scoreboard bench: wrap and saturate counters share stimulus; expected values are queued
// by the stimulus process and checked by an independent monitor.
module tb_inc_dec_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       inc = 1'b0;
    logic [3:0] step = '0;
    logic       load = 1'b0;
    logic [7:0] load_value = '0;

    logic [7:0] w_q, s_q;
    logic       w_cout, w_zero, w_at_max;
    logic       s_cout, s_zero, s_at_max;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] wq;
        logic       wc;
        logic [7:0] sq;
        logic       sc;
    } exp_t;

    exp_t sb[$];
    event smp_ev;

    always #5 clk = ~clk;

    inc_dec_counter #(
        .WIDTH       (8),
        .STEP_WIDTH  (4),
        .MODE        (0),
        .RESET_VALUE (8'h10)
    ) dut_w (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .inc        (inc),
        .step       (step),
        .load       (load),
        .load_value (load_value),
        .q          (w_q),
        .cout       (w_cout),
        .zero       (w_zero),
        .at_max     (w_at_max)
    );

    inc_dec_counter #(
        .WIDTH       (8),
        .STEP_WIDTH  (4),
        .MODE        (1),
        .RESET_VALUE (8'h10)
    ) dut_s (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .inc        (inc),
        .step       (step),
        .load       (load),
        .load_value (load_value),
        .q          (s_q),
        .cout       (s_cout),
        .zero       (s_zero),
        .at_max     (s_at_max)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry is consumed per clock edge (or reset probe) when pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or smp_ev);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wrap_q",      w_q,      e.wq);
                chk("wrap_cout",   {7'd0, w_cout},   {7'd0, e.wc});
                chk("wrap_zero",   {7'd0, w_zero},   {7'd0, (e.wq == 8'h00)});
                chk("wrap_at_max", {7'd0, w_at_max}, {7'd0, (e.wq == 8'hFF)});
                chk("sat_q",       s_q,      e.sq);
                chk("sat_cout",    {7'd0, s_cout},   {7'd0, e.sc});
                chk("sat_zero",    {7'd0, s_zero},   {7'd0, (e.sq == 8'h00)});
                chk("sat_at_max",  {7'd0, s_at_max}, {7'd0, (e.sq == 8'hFF)});
            end
        end
    end

    task automatic push(input logic [7:0] wq, input logic wc, input logic [7:0] sq, input logic sc);
        exp_t e;
        e.wq = wq; e.wc = wc; e.sq = sq; e.sc = sc;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic ld, input logic [7:0] lv, input logic e, input logic i,
                       input logic [3:0] s, input logic [7:0] wq, input logic wc,
                       input logic [7:0] sq, input logic sc);
        @(posedge clk);
        #2;
        load = ld; load_value = lv; en = e; inc = i; step = s;
        push(wq, wc, sq, sc);
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        #2;
        rst = 1'b1;
        push(8'h10, 1'b0, 8'h10, 1'b0);
        -> smp_ev;
    endtask

    task automatic rst_release(input logic [7:0] wq, input logic wc, input logic [7:0] sq, input logic sc);
        @(posedge clk);
        #2;
        rst = 1'b0;
        push(wq, wc, sq, sc);
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1;
        rst = 1'b1;
        push(8'h10, 1'b0, 8'h10, 1'b0);
        -> smp_ev;
        rst_release(8'h10, 1'b0, 8'h10, 1'b0);

        //  ld  lv     en    inc   step   wrap q/c       sat q/c
        cyc(1, 8'hFE, 1'b0, 1'b0, 4'd0,  8'hFE, 1'b0, 8'hFE, 1'b0);
        cyc(0, 8'h00, 1'b1, 1'b1, 4'd3,  8'h01, 1'b1, 8'hFF, 1'b1);
        cyc(0, 8'h00, 1'b0, 1'b0, 4'd0,  8'h01, 1'b0, 8'hFF, 1'b0);
        cyc(1, 8'h02, 1'b0, 1'b0, 4'd0,  8'h02, 1'b0, 8'h02, 1'b0);
        cyc(0, 8'h00, 1'b1, 1'b0, 4'd5,  8'hFD, 1'b1, 8'h00, 1'b1);
        cyc(1, 8'h02, 1'b0, 1'b0, 4'd0,  8'h02, 1'b0, 8'h02, 1'b0);
        cyc(0, 8'h00, 1'b1, 1'b0, 4'd2,  8'h00, 1'b0, 8'h00, 1'b0);
        cyc(0, 8'h00, 1'b1, 1'b0, 4'd1,  8'hFF, 1'b1, 8'h00, 1'b1);
        cyc(1, 8'hFC, 1'b0, 1'b0, 4'd0,  8'hFC, 1'b0, 8'hFC, 1'b0);
        cyc(0, 8'h00, 1'b1, 1'b1, 4'd7,  8'h03, 1'b1, 8'hFF, 1'b1);
        cyc(0, 8'h00, 1'b1, 1'b1, 4'd7,  8'h0A, 1'b0, 8'hFF, 1'b1);
        cyc(0, 8'h00, 1'b1, 1'b1, 4'd0,  8'h0A, 1'b0, 8'hFF, 1'b0);
        cyc(1, 8'h55, 1'b1, 1'b1, 4'd1,  8'h55, 1'b0, 8'h55, 1'b0);
        cyc(0, 8'h00, 1'b1, 1'b1, 4'd0,  8'h55, 1'b0, 8'h55, 1'b0);
        cyc(0, 8'h00, 1'b1, 1'b1, 4'd15, 8'h64, 1'b0, 8'h64, 1'b0);
        cyc(1, 8'hFC, 1'b0, 1'b0, 4'd0,  8'hFC, 1'b0, 8'hFC, 1'b0);
        cyc(0, 8'h00, 1'b1, 1'b1, 4'd3,  8'hFF, 1'b0, 8'hFF, 1'b0);
        cyc(0, 8'h00, 1'b1, 1'b1, 4'd1,  8'h00, 1'b1, 8'hFF, 1'b1);
        cyc(1, 8'h40, 1'b0, 1'b0, 4'd0,  8'h40, 1'b0, 8'h40, 1'b0);
        cyc(0, 8'h00, 1'b1, 1'b1, 4'd1,  8'h41, 1'b0, 8'h41, 1'b0);
        cyc(0, 8'h00, 1'b1, 1'b1, 4'd1,  8'h42, 1'b0, 8'h42, 1'b0);

        // Reset lands between edges while still enabled; counting resumes from the reset value.
        rst_pulse();
        rst_release(8'h11, 1'b0, 8'h11, 1'b0);
        cyc(0, 8'h00, 1'b1, 1'b1, 4'd1,  8'h12, 1'b0, 8'h12, 1'b0);
        cyc(0, 8'h00, 1'b0, 1'b0, 4'd0,  8'h12, 1'b0, 8'h12, 1'b0);

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
